// File: rtl/b11_out_capture.sv
// Change-driven sample capture into a 4-entry FIFO with sticky overflow flag.
// Optional checksum accumulator: define B11_CAP_CKSUM_EN to build it; otherwise cksum is tied to 0.
module b11_out_capture (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] x_in,
  input  logic       cap_en,
  input  logic       out_ready,
  output logic [5:0] out_data,
  output logic       out_valid,
  output logic [2:0] count,
  output logic       overflow,
  output logic [7:0] cksum
);

  localparam int unsigned DW    = 6;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = 2;
  localparam int unsigned CW    = 3;
  localparam int unsigned SW    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   prev_q, prev_d;
  logic [DW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  logic            overflow_q;
  logic            push_c;
  logic            pop_c;
  logic            full_c;
  logic            accept_c;
  logic            drop_c;

  // Capture FSM state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
    end
  end

  // Next state and push decision; dropping cap_en aborts from any state
  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    push_c  = 1'b0;
    if (!cap_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FIRST;
        end
        ST_FIRST: begin
          push_c  = 1'b1;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          push_c = (x_in != prev_q);
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    if (push_c) begin
      prev_d = x_in;
    end
  end

  // A pop in the same cycle frees the slot the push needs when full
  assign pop_c    = (count_q != '0) && out_ready;
  assign full_c   = (count_q == CW'(DEPTH));
  assign accept_c = push_c && (!full_c || pop_c);
  assign drop_c   = push_c && !accept_c;

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept_c) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (accept_c && !pop_c) begin
        count_q <= count_q + CW'(1);
      end else if (pop_c && !accept_c) begin
        count_q <= count_q - CW'(1);
      end
      if (drop_c) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Storage is not reset; stale entries are masked at the output
  always_ff @(posedge clock) begin
    if (accept_c) begin
      mem_q[wr_ptr_q] <= x_in;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;

`ifdef B11_CAP_CKSUM_EN
  logic [SW-1:0] cksum_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cksum_q <= '0;
    end else if (accept_c) begin
      cksum_q <= cksum_q + SW'({2'b00, x_in});
    end
  end

  assign cksum = cksum_q;
`else
  assign cksum = 8'h00;
`endif

endmodule

// File: doc/b11_out_capture.md
B11_OUT_CAPTURE -- requirements
Module: b11_out_capture

Interface
REQ-001 The block SHALL have the port `clock`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port `reset`, input, 1 bit: synchronous, active-low reset; `reset`==0 at a rising edge resets the block.
REQ-003 The block SHALL have the port `x_in`, input, 6 bits: sample stream from the upstream recognizer's `x_out`, sampled every cycle.
REQ-004 The block SHALL have the port `cap_en`, input, 1 bit: capture enable.
REQ-005 The block SHALL have the port `out_ready`, input, 1 bit: consumer accepts the head entry.
REQ-006 The block SHALL have the port `out_data`, output, 6 bits: head-of-FIFO sample.
REQ-007 The block SHALL have the port `out_valid`, output, 1 bit: `out_data` holds a valid entry.
REQ-008 The block SHALL have the port `count`, output, 3 bits: FIFO occupancy, 0..4.
REQ-009 The block SHALL have the port `overflow`, output, 1 bit: sticky flag for a dropped sample.
REQ-010 The block SHALL have the port `cksum`, output, 8 bits: running checksum of accepted samples.

Function
REQ-011 The block SHALL contain a 4-entry x 6-bit FIFO with read pointer, write pointer and occupancy counter, all registered; `out_valid` SHALL equal (`count` != 0), and `out_data` SHALL be the entry at the read pointer.
REQ-012 Capture FSM states SHALL be IDLE, FIRST and TRACK.
- IDLE: `cap_en`=0; no push.
- IDLE->FIRST when `cap_en`=1.
- FIRST: unconditionally push `x_in`, load `prev`<=`x_in`, go to TRACK.
- TRACK: push only when `x_in` != `prev`; on push, `prev`<=`x_in`.
- Any state SHALL go to IDLE in the cycle `cap_en`=0, with no push in that cycle.
REQ-013 A push decided at edge N SHALL be visible at edge N+1: `count` incremented, and `out_valid`=1 if the FIFO was empty (1-cycle latency, no bypass).
REQ-014 A pop SHALL occur at an edge where `out_valid`=1 and `out_ready`=1; the read pointer advances, modulo 4.
REQ-015 Pointers SHALL wrap modulo 4; `count` SHALL never exceed 4 or go below 0.
REQ-016 Simultaneous push and pop SHALL leave `count` unchanged; when full (`count`=4), a simultaneous pop SHALL make room, so the push is accepted and no overflow is flagged.
REQ-017 Push with `count`=4 and no pop: the sample SHALL be dropped, FIFO unchanged, `overflow`<=1, and `prev` still updated.
REQ-018 `overflow` SHALL stay 1 until reset.
REQ-019 `out_ready` while `out_valid`=0 SHALL have no effect.
REQ-020 Checksum: on every accepted push, `cksum`<=(`cksum` + {2'b00,`x_in`}) mod 256; dropped samples SHALL NOT be added.

Reset
REQ-021 When `reset`=0 at a rising edge, the block SHALL set: FSM=IDLE, pointers=0, `count`=0, `out_valid`=0, `out_data`=0, `overflow`=0, `cksum`=0, `prev`=0; FIFO contents SHALL be don't-care but never visible.
REQ-022 Reset SHALL take priority over push, pop and `cap_en` in the same cycle; reset mid-stream discards all entries.

Configuration
REQ-023 With macro `B11_CAP_CKSUM_EN` defined, the checksum accumulator of REQ-020 SHALL be built and drive `cksum`.
REQ-024 Without `B11_CAP_CKSUM_EN`, no accumulator SHALL be built and `cksum` SHALL be constant 8'h00; the port SHALL be retained and all other behaviour SHALL be identical.

Verification
REQ-025 Scenario: reset=0 for 2 cycles, then reset=1, cap_en=1, x_in=6'h05 held, out_ready=0 -> exactly one push; count=1, out_data=6'h05, cksum=8'h05 (macro on).
REQ-026 Scenario: x_in sequence 05,05,0A,0A,3F with cap_en=1, out_ready=0 -> count=3, overflow=0, entries 05,0A,3F, cksum=8'h4E.
REQ-027 Scenario: six distinct values 01..06, out_ready=0 -> count=4, overflow=1, FIFO holds 01..04, cksum=8'h0A.
REQ-028 Scenario: FIFO full, push 07 in the same cycle as out_ready=1 -> count stays 4, overflow unchanged, 07 at the tail.
REQ-029 Scenario: cap_en 1->0->1 with x_in=6'h12 held -> 6'h12 pushed twice (FIRST re-entered).
REQ-030 Scenario: reset=0 asserted with count=3 and a push pending -> next cycle count=0, out_valid=0, cksum=0, overflow=0; build without macro -> cksum=0 throughout REQ-026.
